// File: rtl/weight_comp_sequencer.sv
// Feeds job vectors into a weight_comp_cell chain, waits for the chain to drain,
// and buffers valid chain results in a small FIFO for the consumer.
module weight_comp_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int CHAIN_LENGTH  = 2,
  parameter int VECTOR_LENGTH = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_index,
  input  logic [DATA_WIDTH-1:0] in_value,
  output logic [DATA_WIDTH-1:0] cell_input_index,
  output logic [DATA_WIDTH-1:0] cell_input_value,
  output logic [DATA_WIDTH:0]   cell_input_result,
  output logic                  cell_input_enable,
  input  logic [DATA_WIDTH:0]   cell_output_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(VECTOR_LENGTH + 1);
  localparam int FW = (CHAIN_LENGTH > 0) ? $clog2(CHAIN_LENGTH + 1) : 1;

  localparam logic [CW-1:0] ELEM_LAST  = CW'(VECTOR_LENGTH - 1);
  localparam logic [CW-1:0] ELEM_ONE   = CW'(1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(CHAIN_LENGTH);
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_elem_cnt;
  logic [FW-1:0]         r_flush_cnt;
  logic                  r_in_ready;
  logic                  r_enable;
  logic [DATA_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0] r_value;
  logic                  r_busy;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_overflow;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_drop;

  assign w_push   = cell_output_result[DATA_WIDTH];
  assign w_empty  = (r_count == {(AW+1){1'b0}});
  assign w_full   = (r_count == CNT_FULL);
  assign w_pop    = ~w_empty & out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;

  assign in_ready          = r_in_ready;
  assign cell_input_index  = r_index;
  assign cell_input_value  = r_value;
  assign cell_input_result = {(DATA_WIDTH+1){1'b0}};
  assign cell_input_enable = r_enable;
  assign busy              = r_busy;
  assign done              = r_done;
  assign overflow          = r_overflow;
  assign out_valid         = ~w_empty;
  assign out_result        = w_empty ? {DATA_WIDTH{1'b0}} : r_mem[r_rd_ptr];

  // Job sequencing: feed elements, then hold the chain idle while it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_elem_cnt  <= {CW{1'b0}};
      r_flush_cnt <= {FW{1'b0}};
      r_in_ready  <= 1'b0;
      r_enable    <= 1'b0;
      r_index     <= {DATA_WIDTH{1'b0}};
      r_value     <= {DATA_WIDTH{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !r_done) begin
            r_state    <= ST_FEED;
            r_elem_cnt <= {CW{1'b0}};
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_FEED: begin
          if (in_valid && r_in_ready) begin
            r_enable   <= 1'b1;
            r_index    <= in_index;
            r_value    <= in_value;
            r_elem_cnt <= r_elem_cnt + ELEM_ONE;
            if (r_elem_cnt == ELEM_LAST) begin
              r_state     <= ST_FLUSH;
              r_in_ready  <= 1'b0;
              r_flush_cnt <= {FW{1'b0}};
            end
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == FLUSH_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + FLUSH_ONE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Result FIFO: captures chain output in every state, sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {(AW+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= cell_output_result[DATA_WIDTH-1:0];
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_weight_comp_sequencer.sv
// Self-checking bench: timeline-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_weight_comp_sequencer;

  localparam int DW    = 32;
  localparam int CL    = 2;
  localparam int VL    = 4;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_index;
  logic [DW-1:0] in_value;
  logic [DW-1:0] cell_input_index;
  logic [DW-1:0] cell_input_value;
  logic [DW:0]   cell_input_result;
  logic          cell_input_enable;
  logic [DW:0]   cell_output_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          busy;
  logic          done;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  weight_comp_sequencer #(
    .DATA_WIDTH(DW), .CHAIN_LENGTH(CL), .VECTOR_LENGTH(VL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_index(in_index), .in_value(in_value),
    .cell_input_index(cell_input_index), .cell_input_value(cell_input_value),
    .cell_input_result(cell_input_result), .cell_input_enable(cell_input_enable),
    .cell_output_result(cell_output_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a job is "busy" from acceptance until a done cycle placed
  // CL+2 cycles after the closing cycle of the final transfer.
  bit            m_busy    = 1'b0;
  bit            m_done    = 1'b0;
  bit            m_en      = 1'b0;
  bit            m_ovf     = 1'b0;
  int            m_taken   = 0;
  int            m_done_at = -1;
  int            cyc       = 0;
  logic [DW-1:0] m_idx     = 32'd0;
  logic [DW-1:0] m_val     = 32'd0;
  logic [DW-1:0] q[$];
  bit            xfer, pop, push, full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_en = 1'b0; m_ovf = 1'b0;
      m_taken = 0; m_done_at = -1; cyc = 0;
      m_idx = 32'd0; m_val = 32'd0;
      q.delete();
    end else begin
      xfer = m_busy && (m_taken < VL) && in_valid;
      m_en = xfer;
      if (xfer) begin
        m_idx = in_index;
        m_val = in_value;
        m_taken++;
        if (m_taken == VL) m_done_at = cyc + CL + 2;
      end
      if (!m_busy && start && !m_done) begin
        m_busy  = 1'b1;
        m_taken = 0;
      end
      pop  = (q.size() > 0) && out_ready;
      push = cell_output_result[DW];
      full = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (push) begin
        if (full && !pop) m_ovf = 1'b1;
        else q.push_back(cell_output_result[DW-1:0]);
      end
      cyc++;
      m_done = (cyc == m_done_at);
      if (m_done) m_busy = 1'b0;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("in_ready",    64'(in_ready),          64'(m_busy && (m_taken < VL)));
    chk("busy",        64'(busy),              64'(m_busy));
    chk("done",        64'(done),              64'(m_done));
    chk("cell_enable", 64'(cell_input_enable), 64'(m_en));
    chk("cell_index",  64'(cell_input_index),  64'(m_idx));
    chk("cell_value",  64'(cell_input_value),  64'(m_val));
    chk("cell_result", 64'(cell_input_result), 64'd0);
    chk("out_valid",   64'(out_valid),         64'(q.size() > 0));
    chk("out_result",  64'(out_result),        64'((q.size() > 0) ? q[0] : 32'd0));
    chk("overflow",    64'(overflow),          64'(m_ovf));
  end

  logic [DW-1:0] el_idx [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
  logic [DW-1:0] el_val [4] = '{32'd2, 32'd3, 32'd4, 32'd5};

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_enable"},   64'(cell_input_enable), 64'd0);
    chk({tag, "_index"},    64'(cell_input_index), 64'd0);
    chk({tag, "_value"},    64'(cell_input_value), 64'd0);
    chk({tag, "_result"},   64'(cell_input_result), 64'd0);
    chk({tag, "_out_valid"},64'(out_valid), 64'd0);
    chk({tag, "_out_res"},  64'(out_result), 64'd0);
    chk({tag, "_busy"},     64'(busy), 64'd0);
    chk({tag, "_done"},     64'(done), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  task automatic do_job(input bit bubbles);
    int ndone;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("job_in_ready", 64'(in_ready), 64'd1);
    chk("job_busy",     64'(busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_index = el_idx[k]; in_value = el_val[k];
      @(negedge clk);
      chk("job_en",  64'(cell_input_enable), 64'd1);
      chk("job_idx", 64'(cell_input_index), 64'(el_idx[k]));
      chk("job_val", 64'(cell_input_value), 64'(el_val[k]));
      in_valid = 1'b0;
      if (bubbles && k < 3) begin
        @(negedge clk);
        chk("job_bubble_en", 64'(cell_input_enable), 64'd0);
      end
    end
    chk("job_ready_after_last", 64'(in_ready), 64'd0);
    ndone = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("flush_en", 64'(cell_input_enable), 64'd0);
      if (k == 3) chk("done_at_3", 64'(done), 64'd1);
      if (done) ndone++;
    end
    chk("done_pulses", 64'(ndone), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_index = 32'd0; in_value = 32'd0;
    out_ready = 1'b0; cell_output_result = 33'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Idle: data offered without start is never accepted.
    in_valid = 1'b1; in_index = 32'd9; in_value = 32'd9;
    repeat (10) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd0);
      chk("idle_enable",   64'(cell_input_enable), 64'd0);
      chk("idle_busy",     64'(busy), 64'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);

    do_job(1'b0);
    do_job(1'b1);

    // Capture with backpressure.
    out_ready = 1'b0;
    cell_output_result = {1'b1, 32'd8};  @(negedge clk);
    cell_output_result = {1'b0, 32'd99}; @(negedge clk);
    cell_output_result = {1'b1, 32'd6};  @(negedge clk);
    cell_output_result = {1'b1, 32'd55}; @(negedge clk);
    cell_output_result = 33'd0;
    chk("cap_head0", 64'(out_result), 64'd8);
    out_ready = 1'b1;
    @(negedge clk); chk("cap_head1", 64'(out_result), 64'd6);
    @(negedge clk); chk("cap_head2", 64'(out_result), 64'd55);
    @(negedge clk); chk("cap_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Overflow: fifth push dropped, then push+pop while full keeps everything.
    for (int k = 0; k < 5; k++) begin
      cell_output_result = {1'b1, 32'(10 + k)};
      @(negedge clk);
    end
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head", 64'(out_result), 64'd10);
    cell_output_result = {1'b1, 32'd15}; out_ready = 1'b1;
    @(negedge clk);
    cell_output_result = 33'd0;
    chk("ovf_pp_head", 64'(out_result), 64'd11);
    @(negedge clk); chk("ovf_d1", 64'(out_result), 64'd12);
    @(negedge clk); chk("ovf_d2", 64'(out_result), 64'd13);
    @(negedge clk); chk("ovf_d3", 64'(out_result), 64'd15);
    @(negedge clk); chk("ovf_empty", 64'(out_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    out_ready = 1'b0;

    // Reset in the middle of FEED, with results pending in the FIFO.
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_index = el_idx[k]; in_value = el_val[k];
      cell_output_result = {1'b1, 32'd77};
      @(negedge clk);
    end
    in_valid = 1'b0; cell_output_result = 33'd0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_job(1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 9) < 2);
      in_valid  = ($urandom_range(0, 9) < 6);
      in_index  = $urandom;
      in_value  = $urandom;
      out_ready = ($urandom_range(0, 9) < 5);
      cell_output_result = {($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, 32'($urandom)};
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; cell_output_result = 33'd0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
